agg_seq_ctrl: RTL and testbench

//  Neuron-accumulation sequencer feeding the aggregation stage of the NN accelerator.

---
 rtl/agg_pkg.sv | 17 +
 rtl/agg_out_sat.sv | 24 ++
 rtl/agg_seq_ctrl.sv | 111 +++++++++++
 tb/tb_agg_seq_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/agg_pkg.sv
// agg_pkg: state encoding, accumulator sizing and saturation limits for the aggregation sequencer
package agg_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;
  function automatic int acc_width(input int w, input int cnt_w);
    return w + cnt_w;
  endfunction
  function automatic int max_pos(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int min_neg(input int w);
    return -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/agg_out_sat.sv
// agg_out_sat: narrows the wide accumulator to W bits and derives the fire flag
// AGG_SAT_EN defined clamps to the signed W-bit range; otherwise the low W bits wrap.
module agg_out_sat
  import agg_pkg::*;
#(
  parameter int W     = 12,
  parameter int ACC_W = 20
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [W-1:0]     data_o,
  output logic             acted_o
);
`ifdef AGG_SAT_EN
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(max_pos(W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(min_neg(W));
  assign data_o = $signed(acc_i) > HI ? W'(max_pos(W)) :
                  $signed(acc_i) < LO ? W'(min_neg(W)) : acc_i[W-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^acc_i[ACC_W-1:W];
  assign data_o    = acc_i[W-1:0];
`endif
  assign acted_o = ~data_o[W-1];
endmodule

// File: rtl/agg_seq_ctrl.sv
// agg_seq_ctrl: sums num_in signed products per neuron and emits num_neur results per layer
// Output narrowing lives in agg_out_sat (AGG_SAT_EN selects clamp vs wrap).
module agg_seq_ctrl
  import agg_pkg::*;
#(
  parameter int W     = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_in,
  input  logic [CNT_W-1:0] num_neur,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_acted,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);
  localparam int ACC_W = acc_width(W, CNT_W);
  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, num_in_q, num_in_d, num_neur_q, num_neur_d, idx_q, idx_d;
  logic [W-1:0] data_q, data_d, sat_data;
  logic acted_q, acted_d, done_q, done_d, sat_acted;
  assign acc_sum = acc_q + {{CNT_W{in_data[W-1]}}, in_data};
  agg_out_sat #(.W(W), .ACC_W(ACC_W)) u_sat (
    .acc_i  (acc_sum),
    .data_o (sat_data),
    .acted_o(sat_acted)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      in_cnt_q   <= '0;
      num_in_q   <= '0;
      num_neur_q <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      acted_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      in_cnt_q   <= in_cnt_d;
      num_in_q   <= num_in_d;
      num_neur_q <= num_neur_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      acted_q    <= acted_d;
      done_q     <= done_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    in_cnt_d   = in_cnt_q;
    num_in_d   = num_in_q;
    num_neur_d = num_neur_q;
    idx_d      = idx_q;
    data_d     = data_q;
    acted_d    = acted_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_in != '0 && num_neur != '0) begin
          state_d    = ACCUM;
          num_in_d   = num_in;
          num_neur_d = num_neur;
          acc_d      = '0;
          in_cnt_d   = '0;
          idx_d      = '0;
        end else done_d = 1'b1;
      end
      ACCUM: if (in_valid) begin
        acc_d    = acc_sum;
        in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == num_in_q - 1'b1) begin
          state_d = EMIT;
          data_d  = sat_data;
          acted_d = sat_acted;
        end
      end
      EMIT: if (out_ready) begin
        if (idx_q == num_neur_q - 1'b1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d  = ACCUM;
          idx_d    = idx_q + 1'b1;
          acc_d    = '0;
          in_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == EMIT;
  assign busy      = state_q != IDLE;
  assign out_data  = data_q;
  assign out_acted = acted_q;
  assign out_idx   = idx_q;
  assign done      = done_q;
endmodule

// File: tb/tb_agg_seq_ctrl.sv
// tb_agg_seq_ctrl: directed vectors with hand-computed sums for agg_seq_ctrl
module tb_agg_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] num_in = '0, num_neur = '0;
  logic [11:0] in_data = '0;
  logic in_ready, out_valid, out_acted, busy, done;
  logic [11:0] out_data;
  logic [7:0] out_idx;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  agg_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_in(num_in), .num_neur(num_neur),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_acted(out_acted), .out_idx(out_idx), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_layer(input int ni, input int nn);
    start = 1'b1; num_in = 8'(ni); num_neur = 8'(nn);
    @(negedge clk);
    start = 1'b0; num_in = $urandom; num_neur = $urandom;
  endtask
  task automatic send(input int d, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) check("send_timeout", 0, 1);
    in_valid = 1'b1; in_data = 12'(d);
    @(negedge clk);
    in_valid = 1'b0; in_data = $urandom;
  endtask
  task automatic get_out(input string tag, input logic [11:0] d, input logic a, input int idx);
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_acted"}, out_acted, a);
    check({tag, "_idx"}, out_idx, idx);
    check({tag, "_ready"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  initial begin
    // reset with random inputs
    repeat (3) begin
      start = $urandom; in_valid = $urandom; out_ready = $urandom; in_data = $urandom;
      num_in = $urandom; num_neur = $urandom;
      @(negedge clk);
    end
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_acted", out_acted, 0);
    check("rst_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    start = 0; in_valid = 0; out_ready = 0;
    rst = 1'b0;
    @(negedge clk);
    // reset mid-accumulation
    start_layer(3, 1);
    send(5, 0);
    check("mid_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1 check("mid_busy_rst", busy, 0);
    @(negedge clk);
    check("mid_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    // 5 - 2 + 10 = 13
    start_layer(3, 1);
    send(5, 0); send(-2, 0); send(10, 0);
    check("t2_done_pre", done, 0);
    get_out("t2", 12'd13, 1'b1, 0);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    @(negedge clk);
    check("t2_done_pulse", done, 0);
    // -100 - 50 = -150
    start_layer(2, 1);
    send(-100, 0); send(-50, 1);
    get_out("t3", 12'hF6A, 1'b0, 0);
    @(negedge clk);
    // 2000 + 2000 overflows 12 bits
    start_layer(2, 1);
    send(2000, 0); send(2000, 0);
`ifdef AGG_SAT_EN
    get_out("t4", 12'h7FF, 1'b1, 0);
`else
    get_out("t4", 12'hFA0, 1'b0, 0);
`endif
    @(negedge clk);
    // backpressure with input gaps: 100 + 200 - 50 + 7 = 257
    start_layer(4, 1);
    send(100, $urandom_range(0, 3)); send(200, $urandom_range(0, 3));
    send(-50, $urandom_range(0, 3)); send(7, $urandom_range(0, 3));
    in_valid = 1'b1; in_data = 12'h123;
    repeat (5) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 12'h101);
      check("bp_idx", out_idx, 0);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    get_out("t5", 12'h101, 1'b1, 0);
    check("t5_done", done, 1);
    @(negedge clk);
    // three single-product neurons
    start_layer(1, 3);
    send(7, 0);
    get_out("t6n0", 12'd7, 1'b1, 0);
    check("t6_done0", done, 0);
    send(-1, 0);
    get_out("t6n1", 12'hFFF, 1'b0, 1);
    check("t6_done1", done, 0);
    send(0, 2);
    get_out("t6n2", 12'd0, 1'b1, 2);
    check("t6_done2", done, 1);
    @(negedge clk);
    check("t6_done_end", done, 0);
    // empty layers finish immediately
    start_layer(0, 5);
    check("zero_in_done", done, 1);
    check("zero_in_busy", busy, 0);
    start_layer(3, 0);
    check("zero_neur_done", done, 1);
    repeat (3) begin
      @(negedge clk);
      check("zero_no_valid", out_valid, 0);
      check("zero_idle", busy, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
